// File: rtl/baw_pkg.sv
// rtl/baw_pkg.sv - shared types, codes and helpers for the automated card player
package baw_pkg;

  localparam int NUM_CARDS = 9;

  typedef enum logic [1:0] {
    STRAT_RANDOM  = 2'd0,
    STRAT_LOWEST  = 2'd1,
    STRAT_HIGHEST = 2'd2,
    STRAT_COUNTER = 2'd3
  } strat_e;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SCAN    = 3'd1,
    ST_HOLD    = 3'd2,
    ST_CONFIRM = 3'd3,
    ST_ERR     = 3'd4
  } state_e;

  // Odd cards are black, matching the referee's handcard[0] convention.
  function automatic logic card_is_black(input logic [3:0] n);
    return n[0];
  endfunction

  // Random start index: the 8-bit LFSR value folded onto 0..8.
  function automatic logic [3:0] mod9(input logic [7:0] v);
    logic [7:0] r;
    r = v % 8'd9;
    return r[3:0];
  endfunction

endpackage

// File: rtl/baw_lfsr8.sv
// rtl/baw_lfsr8.sv - 8-bit Fibonacci LFSR (x^8+x^6+x^5+x^4+1) with zero-safe seeding
module baw_lfsr8 #(
  parameter logic [7:0] SEED_DEFAULT = 8'h01
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [7:0] load_val,
  input  logic       step,
  output logic [7:0] value
);

  logic fb;

  assign fb = value[7] ^ value[5] ^ value[4] ^ value[3];

  // A zero seed would lock the register, so it is replaced by 8'h01; load beats step.
  always_ff @(posedge clk) begin
    if (reset) begin
      value <= (SEED_DEFAULT == 8'h00) ? 8'h01 : SEED_DEFAULT;
    end else if (load) begin
      value <= (load_val == 8'h00) ? 8'h01 : load_val;
    end else if (step) begin
      value <= {value[6:0], fb};
    end
  end

endmodule

// File: rtl/baw_cpu_player.sv
// rtl/baw_cpu_player.sv - automated opponent: picks, holds and confirms one card per turn
module baw_cpu_player
  import baw_pkg::*;
#(
  parameter int         HOLD_CYCLES  = 4,
  parameter logic [7:0] SEED_DEFAULT = 8'h01
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 turn_req,
  input  logic [NUM_CARDS-1:0] avail_mask,
  input  logic [1:0]           strategy,
  input  logic                 opp_played,
  input  logic                 opp_black,
  input  logic                 seed_load,
  input  logic [7:0]           seed,
  output logic [NUM_CARDS-1:0] card_onehot,
  output logic [3:0]           card_num,
  output logic                 card_valid,
  output logic                 confirm,
  output logic                 busy,
  output logic                 error
);

  localparam logic [3:0] HOLD_LAST = 4'(HOLD_CYCLES - 1);
  localparam logic [3:0] TOP_CARD  = 4'(NUM_CARDS - 1);

  state_e               state, state_n;
  logic [NUM_CARDS-1:0] snap, snap_n;
  logic [3:0]           ptr, ptr_n;
  logic                 desc, desc_n;
  logic [3:0]           card, card_n;
  logic [3:0]           cnt, cnt_n;
  logic [7:0]           lfsr_val;
  logic                 lfsr_load;
  logic                 lfsr_step;

  baw_lfsr8 #(
    .SEED_DEFAULT(SEED_DEFAULT)
  ) u_lfsr (
    .clk     (clk),
    .reset   (reset),
    .load    (lfsr_load),
    .load_val(seed),
    .step    (lfsr_step),
    .value   (lfsr_val)
  );

  // State and datapath registers; reset abandons any turn in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      snap  <= '0;
      ptr   <= '0;
      desc  <= 1'b0;
      card  <= '0;
      cnt   <= '0;
    end else begin
      state <= state_n;
      snap  <= snap_n;
      ptr   <= ptr_n;
      desc  <= desc_n;
      card  <= card_n;
      cnt   <= cnt_n;
    end
  end

  // Turn sequencing: snapshot and pick start point, scan for a card, hold, confirm.
  always_comb begin
    state_n   = state;
    snap_n    = snap;
    ptr_n     = ptr;
    desc_n    = desc;
    card_n    = card;
    cnt_n     = cnt;
    lfsr_load = 1'b0;
    lfsr_step = 1'b0;
    case (state)
      ST_IDLE: begin
        if (seed_load) begin
          lfsr_load = 1'b1;
        end else if (turn_req) begin
          lfsr_step = 1'b1;
          snap_n    = avail_mask;
          if (avail_mask == '0) begin
            state_n = ST_ERR;
          end else begin
            state_n = ST_SCAN;
            ptr_n   = mod9(lfsr_val);
            desc_n  = 1'b0;
            case (strat_e'(strategy))
              STRAT_LOWEST: begin
                ptr_n  = 4'd0;
                desc_n = 1'b0;
              end
              STRAT_HIGHEST: begin
                ptr_n  = TOP_CARD;
                desc_n = 1'b1;
              end
              STRAT_COUNTER: begin
                if (opp_played) begin
                  ptr_n  = opp_black ? TOP_CARD : 4'd0;
                  desc_n = opp_black;
                end
              end
              default: ;
            endcase
          end
        end
      end
      ST_SCAN: begin
        if (snap[ptr]) begin
          card_n  = ptr;
          cnt_n   = 4'd0;
          state_n = ST_HOLD;
        end else if (desc) begin
          ptr_n = (ptr == 4'd0) ? TOP_CARD : ptr - 4'd1;
        end else begin
          ptr_n = (ptr == TOP_CARD) ? 4'd0 : ptr + 4'd1;
        end
      end
      ST_HOLD: begin
        if (cnt == HOLD_LAST) begin
          state_n = ST_CONFIRM;
        end else begin
          cnt_n = cnt + 4'd1;
        end
      end
      ST_CONFIRM: state_n = ST_IDLE;
      ST_ERR:     state_n = ST_IDLE;
      default:    state_n = ST_IDLE;
    endcase
  end

  assign card_valid  = (state == ST_HOLD) || (state == ST_CONFIRM);
  assign card_num    = card_valid ? card : 4'd0;
  assign card_onehot = card_valid ? (NUM_CARDS'(1) << card) : '0;
  assign confirm     = (state == ST_CONFIRM);
  assign busy        = (state != ST_IDLE);
  assign error       = (state == ST_ERR);

endmodule
